popcnt_class: RTL

POPCNT_CLASS -- requirements
Module: popcnt_class

---
 rtl/popcnt_class.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/popcnt_class.sv
// popcnt_class: two-stage population-count classifier with valid/ready handshake.
// Optional feature: define POPCNT_CLASS_FRAME_EN to accumulate counts across the
// beats of a frame. The last beat is marked by in_last, and only that beat
// produces an output.
// Ports:
//   clk, rst_n              clock and synchronous active-low reset
//   in_vld/in_rdy           input beat handshake
//   in_x, in_inv, in_last   data word, count-zeros control, frame end marker
//   out_vld/out_rdy         result handshake
//   out_cnt                 saturated count
//   out_has_set_0/1/_more_than_1, out_ge_th   count classification flags
//   out_sat                 accumulator saturated within the frame
module popcnt_class #(
  parameter int unsigned W  = 32,
  parameter int unsigned CW = 16,
  parameter int unsigned TH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [W-1:0]  in_x,
  input  logic          in_inv,
  input  logic          in_last,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [CW-1:0] out_cnt,
  output logic          out_has_set_0,
  output logic          out_has_set_1,
  output logic          out_has_set_more_than_1,
  output logic          out_ge_th,
  output logic          out_sat
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic          s1_vld;
  logic [CW-1:0] s1_pc;
  logic          s2_adv;
  logic          s1_adv;
  logic [W-1:0]  x_cond;
  logic [CW-1:0] pc;
  logic [CW-1:0] sum_sat;
  logic          sat_nxt;
  logic          emit;
  logic          is_0;
  logic          is_1;

  // Stage advance terms. in_rdy depends only on registered state and out_rdy.
  assign s2_adv = ~out_vld | out_rdy;
  assign s1_adv = s1_vld & s2_adv;
  assign in_rdy = ~s1_vld | s2_adv;

  // Conditional inversion followed by the population count.
  always_comb begin
    x_cond = in_x ^ {W{in_inv}};
    pc     = '0;
    for (int i = 0; i < W; i++) begin
      pc = pc + CW'(x_cond[i]);
    end
  end

`ifdef POPCNT_CLASS_FRAME_EN
  logic          s1_last;
  logic [CW-1:0] acc;
  logic          frame_sat;
  logic [CW:0]   sum_w;
  logic          sum_ovf;

  // The sum is one bit wider than acc, so saturation is detected without wrap.
  always_comb begin
    sum_w   = {1'b0, acc} + {1'b0, s1_pc};
    sum_ovf = (sum_w > {1'b0, CNT_MAX});
    sum_sat = sum_ovf ? CNT_MAX : sum_w[CW-1:0];
    sat_nxt = sum_ovf | frame_sat;
    emit    = s1_last;
  end

  // Frame state: running sum and sticky saturation. Both clear once the last beat leaves S1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      frame_sat <= 1'b0;
      s1_last   <= 1'b0;
    end else begin
      if (in_rdy && in_vld) begin
        s1_last <= in_last;
      end
      if (s1_adv) begin
        if (s1_last) begin
          acc       <= '0;
          frame_sat <= 1'b0;
        end else begin
          acc       <= sum_sat;
          frame_sat <= sat_nxt;
        end
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = in_last;

  // Every beat is a result on its own. pc never exceeds W, so it cannot saturate.
  always_comb begin
    sum_sat = s1_pc;
    sat_nxt = 1'b0;
    emit    = 1'b1;
  end
`endif

  assign is_0 = (sum_sat == '0);
  assign is_1 = (sum_sat == CW'(1));

  // S1: capture the beat count whenever the stage can take a new beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_pc  <= '0;
    end else if (in_rdy) begin
      s1_vld <= in_vld;
      if (in_vld) begin
        s1_pc <= pc;
      end
    end
  end

  // S2: output registers. They are held while out_vld & ~out_rdy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld                 <= 1'b0;
      out_cnt                 <= '0;
      out_has_set_0           <= 1'b1;
      out_has_set_1           <= 1'b0;
      out_has_set_more_than_1 <= 1'b0;
      out_ge_th               <= 1'b0;
      out_sat                 <= 1'b0;
    end else if (s2_adv) begin
      out_vld <= s1_adv & emit;
      if (s1_adv && emit) begin
        out_cnt                 <= sum_sat;
        out_has_set_0           <= is_0;
        out_has_set_1           <= is_1;
        out_has_set_more_than_1 <= ~(is_0 | is_1);
        out_ge_th               <= (32'(sum_sat) >= 32'(TH));
        out_sat                 <= sat_nxt;
      end
    end
  end

endmodule
